// File: rtl/rtc_pkg.sv
// Shared RTC bus constants: register addresses, per-register step schedule and idle levels.
// Both the initialisation writer and the read-back controller sequence the bus from these steps.
package rtc_pkg;

  typedef logic [5:0] step_t;
  typedef logic [1:0] idx_t;

  localparam logic [7:0] DEF_ADDR_SEG = 8'h21;
  localparam logic [7:0] DEF_ADDR_MIN = 8'h22;
  localparam logic [7:0] DEF_ADDR_HOR = 8'h23;

  // One register access: address phase (AD/CS/WR low, bus driven), then read phase (CS/RD low).
  localparam step_t STEP_SEL     = 6'd0;
  localparam step_t STEP_AD_LO   = 6'd1;
  localparam step_t STEP_CS_LO   = 6'd2;
  localparam step_t STEP_WR_LO   = 6'd3;
  localparam step_t STEP_DRIVE   = 6'd4;
  localparam step_t STEP_WR_HI   = 6'd9;
  localparam step_t STEP_CS_HI   = 6'd10;
  localparam step_t STEP_AD_HI   = 6'd11;
  localparam step_t STEP_RELEASE = 6'd13;
  localparam step_t STEP_CS_RD   = 6'd21;
  localparam step_t STEP_RD_LO   = 6'd22;
  localparam step_t STEP_SAMPLE  = 6'd28;
  localparam step_t STEP_RD_HI   = 6'd29;
  localparam step_t STEP_CS_END  = 6'd30;
  localparam step_t STEP_END     = 6'd40;

  localparam idx_t IDX_SEG  = 2'd0;
  localparam idx_t IDX_MIN  = 2'd1;
  localparam idx_t IDX_HOR  = 2'd2;
  localparam idx_t IDX_LAST = IDX_HOR;

  localparam logic       STROBE_IDLE = 1'b1;
  localparam logic [7:0] BUS_IDLE    = 8'hFF;

  function automatic logic [7:0] reg_addr(input idx_t idx, input logic [7:0] a_seg,
                                          input logic [7:0] a_min, input logic [7:0] a_hor);
    logic [7:0] a;
    case (idx)
      IDX_SEG: a = a_seg;
      IDX_MIN: a = a_min;
      default: a = a_hor;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector: registers the input once and flags cycles where it is high but was low.
// The flag is combinational from the input; the consumer registers it, so no input reaches a pin.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic senal_i,
  output logic senal_d_o,
  output logic flanco_o
);

  logic senal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      senal_q <= 1'b0;
    end else begin
      senal_q <= senal_i;
    end
  end

  assign senal_d_o = senal_q;
  assign flanco_o  = senal_i & ~senal_q;

endmodule

// File: rtl/rtc_lector.sv
// RTC read-back: on a rising edge of leer, reads seconds/minutes/hours over the AD bus (41 steps each)
// and presents all three with a one-cycle dato_valido, 123 cycles after ocupado rises.
module rtc_lector
  import rtc_pkg::*;
#(
  parameter logic [7:0] ADDR_SEG = DEF_ADDR_SEG,
  parameter logic [7:0] ADDR_MIN = DEF_ADDR_MIN,
  parameter logic [7:0] ADDR_HOR = DEF_ADDR_HOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leer,
  input  logic [7:0] dato_in,
  output logic [7:0] dato_out,
  output logic       bus_oe,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       AD,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic       dato_valido,
  output logic       ocupado
);

  localparam logic S_IDLE     = 1'b0;
  localparam logic S_BUSCYCLE = 1'b1;

  logic leer_d;
  logic flanco;

  detector_flanco u_flanco (
    .clk      (clk),
    .reset    (reset),
    .senal_i  (leer),
    .senal_d_o(leer_d),
    .flanco_o (flanco)
  );

  logic             state_q, state_d;
  step_t            c_q, c_d;
  idx_t             i_q, i_d;
  logic             cs_q, cs_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             ad_q, ad_d;
  logic [7:0]       dato_out_q, dato_out_d;
  logic             bus_oe_q, bus_oe_d;
  logic [2:0][7:0]  sh_q, sh_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       hor_q, hor_d;
  logic             valido_q, valido_d;
  logic             ocupado_q, ocupado_d;

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    i_d        = i_q;
    cs_d       = cs_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ad_d       = ad_q;
    dato_out_d = dato_out_q;
    bus_oe_d   = bus_oe_q;
    sh_d       = sh_q;
    seg_d      = seg_q;
    min_d      = min_q;
    hor_d      = hor_q;
    valido_d   = 1'b0;
    ocupado_d  = ocupado_q;

    case (state_q)
      S_IDLE: begin
        if (flanco) begin
          state_d   = S_BUSCYCLE;
          ocupado_d = 1'b1;
          i_d       = IDX_SEG;
          c_d       = STEP_SEL;
        end
      end

      default: begin
        c_d = c_q + 6'd1;
        case (c_q)
          STEP_SEL: begin
            cs_d = STROBE_IDLE;
            rd_d = STROBE_IDLE;
            wr_d = STROBE_IDLE;
            ad_d = STROBE_IDLE;
          end
          STEP_AD_LO: ad_d = ~STROBE_IDLE;
          STEP_CS_LO: cs_d = ~STROBE_IDLE;
          STEP_WR_LO: wr_d = ~STROBE_IDLE;
          STEP_DRIVE: begin
            dato_out_d = reg_addr(i_q, ADDR_SEG, ADDR_MIN, ADDR_HOR);
            bus_oe_d   = 1'b1;
          end
          STEP_WR_HI: wr_d = STROBE_IDLE;
          STEP_CS_HI: cs_d = STROBE_IDLE;
          STEP_AD_HI: ad_d = STROBE_IDLE;
          // Bus is released well before RD falls so the RTC never fights our drivers.
          STEP_RELEASE: begin
            bus_oe_d   = 1'b0;
            dato_out_d = BUS_IDLE;
          end
          STEP_CS_RD:  cs_d = ~STROBE_IDLE;
          STEP_RD_LO:  rd_d = ~STROBE_IDLE;
          STEP_SAMPLE: sh_d[i_q] = dato_in;
          STEP_RD_HI:  rd_d = STROBE_IDLE;
          STEP_CS_END: cs_d = STROBE_IDLE;
          STEP_END: begin
            c_d = STEP_SEL;
            if (i_q < IDX_LAST) begin
              i_d = i_q + 2'd1;
            end else begin
              // Publish only complete triples; a reset before here discards the shadows.
              seg_d     = sh_q[IDX_SEG];
              min_d     = sh_q[IDX_MIN];
              hor_d     = sh_q[IDX_HOR];
              valido_d  = 1'b1;
              ocupado_d = 1'b0;
              state_d   = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      c_q        <= STEP_SEL;
      i_q        <= IDX_SEG;
      cs_q       <= STROBE_IDLE;
      rd_q       <= STROBE_IDLE;
      wr_q       <= STROBE_IDLE;
      ad_q       <= STROBE_IDLE;
      dato_out_q <= BUS_IDLE;
      bus_oe_q   <= 1'b0;
      sh_q       <= '0;
      seg_q      <= 8'h00;
      min_q      <= 8'h00;
      hor_q      <= 8'h00;
      valido_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      i_q        <= i_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ad_q       <= ad_d;
      dato_out_q <= dato_out_d;
      bus_oe_q   <= bus_oe_d;
      sh_q       <= sh_d;
      seg_q      <= seg_d;
      min_q      <= min_d;
      hor_q      <= hor_d;
      valido_q   <= valido_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign dato_out    = dato_out_q;
  assign bus_oe      = bus_oe_q;
  assign CS          = cs_q;
  assign RD          = rd_q;
  assign WR          = wr_q;
  assign AD          = ad_q;
  assign segundos    = seg_q;
  assign minutos     = min_q;
  assign horas       = hor_q;
  assign dato_valido = valido_q;
  assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_rtc_lector.sv
// Directed bench for rtc_lector with a small RTC bus model that answers by latched address.
module tb_rtc_lector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       leer = 1'b0;
  logic [7:0] dato_in;
  logic [7:0] dato_out;
  logic       bus_oe, CS, RD, WR, AD;
  logic [7:0] segundos, minutos, horas;
  logic       dato_valido, ocupado;

  logic [7:0] cur_addr = 8'h00;
  logic [7:0] r_seg = 8'h00;
  logic [7:0] r_min = 8'h00;
  logic [7:0] r_hor = 8'h00;

  int total = 0;
  int bad = 0;

  rtc_lector dut (
    .clk        (clk),
    .reset      (reset),
    .leer       (leer),
    .dato_in    (dato_in),
    .dato_out   (dato_out),
    .bus_oe     (bus_oe),
    .CS         (CS),
    .RD         (RD),
    .WR         (WR),
    .AD         (AD),
    .segundos   (segundos),
    .minutos    (minutos),
    .horas      (horas),
    .dato_valido(dato_valido),
    .ocupado    (ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_oe) cur_addr <= dato_out;

  assign dato_in = (cur_addr == 8'h21) ? r_seg :
                   (cur_addr == 8'h22) ? r_min :
                   (cur_addr == 8'h23) ? r_hor : 8'hEE;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    leer  = 1'b0;
    repeat (3) step();
    total++;
    if ({CS, RD, WR, AD, bus_oe, dato_valido, ocupado} !== 7'b1111000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=1111000", {CS, RD, WR, AD, bus_oe, dato_valido, ocupado});
    end
    total++;
    if (dato_out !== 8'hFF) begin
      bad++;
      $display("FAIL reset_dato_out got=%h exp=ff", dato_out);
    end
    total++;
    if ({segundos, minutos, horas} !== 24'h000000) begin
      bad++;
      $display("FAIL reset_time got=%h exp=000000", {segundos, minutos, horas});
    end
    reset = 1'b0;
    repeat (5) step();
    total++;
    if ({ocupado, dato_valido} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset got=%b exp=00", {ocupado, dato_valido});
    end
  endtask

  task automatic test_single_read();
    int found = 0;
    int oe_cnt = 0, rd_cnt = 0, wr_cnt = 0, ad_cnt = 0;
    int addr_err = 0, ovl_err = 0;
    r_seg = 8'h45; r_min = 8'h30; r_hor = 8'h12;
    leer = 1'b1;
    step();
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL start_ocupado got=%b exp=1", ocupado);
    end
    leer = 1'b0;
    for (int n = 1; n <= 200 && found == 0; n++) begin
      step();
      if (bus_oe) begin
        oe_cnt++;
        if (dato_out !== 8'h21 + 8'((oe_cnt - 1) / 9)) addr_err++;
      end else if (dato_out !== 8'hFF) addr_err++;
      if (!RD) begin
        rd_cnt++;
        if (bus_oe) ovl_err++;
      end
      if (!WR) begin
        wr_cnt++;
        if (CS || AD) ovl_err++;
      end
      if (!AD) ad_cnt++;
      if (dato_valido) found = n;
    end
    total++;
    if (found != 123) begin
      bad++;
      $display("FAIL valid_latency got=%0d exp=123", found);
    end
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL ocupado_fall got=%b exp=0", ocupado);
    end
    total++;
    if ({segundos, minutos, horas} !== 24'h453012) begin
      bad++;
      $display("FAIL read_values got=%h exp=453012", {segundos, minutos, horas});
    end
    total++;
    if (oe_cnt != 27 || rd_cnt != 21 || wr_cnt != 18 || ad_cnt != 30) begin
      bad++;
      $display("FAIL strobe_widths got=oe%0d rd%0d wr%0d ad%0d exp=oe27 rd21 wr18 ad30",
               oe_cnt, rd_cnt, wr_cnt, ad_cnt);
    end
    total++;
    if (addr_err != 0) begin
      bad++;
      $display("FAIL bus_address got=%0d errors exp=0", addr_err);
    end
    total++;
    if (ovl_err != 0) begin
      bad++;
      $display("FAIL strobe_overlap got=%0d errors exp=0", ovl_err);
    end
    step();
    total++;
    if (dato_valido !== 1'b0) begin
      bad++;
      $display("FAIL valid_one_cycle got=%b exp=0", dato_valido);
    end
  endtask

  task automatic test_reset_idle();
    reset = 1'b1;
    step();
    total++;
    if ({segundos, minutos, horas, dato_out} !== 32'h000000FF ||
        {CS, RD, WR, AD, bus_oe, dato_valido, ocupado} !== 7'b1111000) begin
      bad++;
      $display("FAIL reset_idle got=%h/%b exp=000000ff/1111000",
               {segundos, minutos, horas, dato_out}, {CS, RD, WR, AD, bus_oe, dato_valido, ocupado});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ignore_second();
    int vcnt = 0, first_at = 0, busy_after = 0;
    r_seg = 8'h07; r_min = 8'h08; r_hor = 8'h09;
    leer = 1'b1;
    step();
    leer = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n == 50) leer = 1'b1;
      if (n == 52) leer = 1'b0;
      if (dato_valido) begin
        vcnt++;
        if (first_at == 0) first_at = n;
      end
      if (n > 123 && ocupado) busy_after++;
    end
    total++;
    if (vcnt != 1 || first_at != 123) begin
      bad++;
      $display("FAIL ignore_second got=cnt%0d at%0d exp=cnt1 at123", vcnt, first_at);
    end
    total++;
    if (busy_after != 0) begin
      bad++;
      $display("FAIL no_queued_start got=%0d busy cycles exp=0", busy_after);
    end
    total++;
    if ({segundos, minutos, horas} !== 24'h070809) begin
      bad++;
      $display("FAIL ignore_values got=%h exp=070809", {segundos, minutos, horas});
    end
  endtask

  task automatic test_hold_high();
    int vcnt = 0, starts = 0;
    logic prev = 1'b0;
    leer = 1'b1;
    for (int n = 0; n < 500; n++) begin
      step();
      if (dato_valido) vcnt++;
      if (ocupado && !prev) starts++;
      prev = ocupado;
    end
    leer = 1'b0;
    step();
    total++;
    if (vcnt != 1 || starts != 1) begin
      bad++;
      $display("FAIL hold_high got=valid%0d starts%0d exp=valid1 starts1", vcnt, starts);
    end
  endtask

  task automatic test_reset_mid();
    int vcnt = 0, busy = 0;
    leer = 1'b1;
    step();
    leer = 1'b0;
    repeat (67) step();
    total++;
    if ({RD, ocupado} !== 2'b01) begin
      bad++;
      $display("FAIL mid_read_phase got=%b exp=01", {RD, ocupado});
    end
    reset = 1'b1;
    step();
    total++;
    if ({segundos, minutos, horas, dato_out} !== 32'h000000FF ||
        {CS, RD, WR, AD, bus_oe, dato_valido, ocupado} !== 7'b1111000) begin
      bad++;
      $display("FAIL reset_mid got=%h/%b exp=000000ff/1111000",
               {segundos, minutos, horas, dato_out}, {CS, RD, WR, AD, bus_oe, dato_valido, ocupado});
    end
    reset = 1'b0;
    for (int n = 0; n < 150; n++) begin
      step();
      if (dato_valido) vcnt++;
      if (ocupado) busy++;
    end
    total++;
    if (vcnt != 0 || busy != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got=valid%0d busy%0d exp=0 0", vcnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    int found = 0, hold_err = 0;
    r_seg = 8'h59; r_min = 8'h59; r_hor = 8'h59;
    leer = 1'b1;
    step();
    leer = 1'b0;
    for (int n = 1; n <= 200 && found == 0; n++) begin
      step();
      if (dato_valido) found = n;
    end
    total++;
    if (found != 123 || {segundos, minutos, horas} !== 24'h595959) begin
      bad++;
      $display("FAIL b2b_first got=at%0d %h exp=at123 595959", found, {segundos, minutos, horas});
    end
    r_seg = 8'h00; r_min = 8'h00; r_hor = 8'h00;
    leer = 1'b1;
    step();
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart got=%b exp=1", ocupado);
    end
    leer = 1'b0;
    found = 0;
    for (int n = 1; n <= 200 && found == 0; n++) begin
      step();
      if (dato_valido) found = n;
      else if ({segundos, minutos, horas} !== 24'h595959) hold_err++;
    end
    total++;
    if (hold_err != 0) begin
      bad++;
      $display("FAIL b2b_hold got=%0d changed cycles exp=0", hold_err);
    end
    total++;
    if (found != 123 || {segundos, minutos, horas} !== 24'h000000) begin
      bad++;
      $display("FAIL b2b_second got=at%0d %h exp=at123 000000", found, {segundos, minutos, horas});
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_reset_idle();
    test_ignore_second();
    test_hold_high();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
